// File: rtl/div_pkg.sv
// +-----------------------------------------------------------------------+
// | div_pkg: shared types and constants for the sequential divider        |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

package div_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_addsub.sv
// +-----------------------------------------------------------------------+
// | div_addsub: N-bit ripple adder/subtractor (mode=1 subtracts b)        |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module div_addsub #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         mode,
  output logic [N-1:0] sum,
  output logic         carry_out
);

  logic [N:0] w_carry;

  assign w_carry[0] = mode;

  for (genvar i = 0; i < N; i++) begin : g_bit
    logic w_bx;
    assign w_bx           = b[i] ^ mode;
    assign sum[i]         = a[i] ^ w_bx ^ w_carry[i];
    assign w_carry[i + 1] = (a[i] & w_bx) | (w_carry[i] & (a[i] ^ w_bx));
  end

  assign carry_out = w_carry[N];

endmodule

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// +-----------------------------------------------------------------------+
// | seq_restoring_divider: multicycle unsigned restoring divider          |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = count_width(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_no_borrow;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic             w_unused;

  // A new request is taken in IDLE and also in the DONE cycle, allowing back-to-back operation.
  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_count == CW'(1));

  assign w_trial = {r_rem, r_quo[WIDTH-1]};

  div_addsub #(
    .N(WIDTH + 1)
  ) u_addsub (
    .a        (w_trial),
    .b        ({1'b0, r_div}),
    .mode     (1'b1),
    .sum      (w_diff),
    .carry_out(w_no_borrow)
  );

  assign w_rem_next = w_no_borrow ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_no_borrow};

  // Top bits are zero whenever they are selected, since R < D holds throughout.
  assign w_unused = ^{w_diff[WIDTH], w_trial[WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_state_next = (divisor != '0) ? RUN : DONE;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_count     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        if (divisor != '0) begin
          r_div   <= divisor;
          r_rem   <= '0;
          r_quo   <= dividend;
          r_count <= CW'(WIDTH);
          busy    <= 1'b1;
        end else begin
          done        <= 1'b1;
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (r_state == RUN) begin
        r_rem   <= w_rem_next;
        r_quo   <= w_quo_next;
        r_count <= r_count - CW'(1);
        if (w_last) begin
          busy        <= 1'b0;
          done        <= 1'b1;
          quotient    <= w_quo_next;
          remainder   <= w_rem_next;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// +-----------------------------------------------------------------------+
// | tb_seq_restoring_divider: randomized and directed checks of divider   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_seq_restoring_divider;

  localparam int W       = 4;
  localparam int TIMEOUT = 40;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks;
  int errors;

  seq_restoring_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division; divide by zero yields all ones and the dividend.
  function automatic void ref_div(input int a, input int b, output int q, output int r,
                                  output int dbz, output int lat);
    if (b == 0) begin
      q = (1 << W) - 1; r = a; dbz = 1; lat = 1;
    end else begin
      q = a / b; r = a % b; dbz = 0; lat = W + 1;
    end
  endfunction

  // Issue one request and wait for done; lat counts edges including the accept edge.
  task automatic run_op(input int a, input int b, output int lat);
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat = 1;
    while (!done && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset: outputs=%h required 0", {busy, done, quotient, remainder, div_by_zero});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    int cases[5][2] = '{'{13, 3}, '{15, 1}, '{5, 14}, '{0, 7}, '{9, 0}};
    int q, r, dbz, lat, got_lat;
    for (int i = 0; i < 5; i++) begin
      ref_div(cases[i][0], cases[i][1], q, r, dbz, lat);
      run_op(cases[i][0], cases[i][1], got_lat);
      checks++;
      if (got_lat != lat || quotient !== W'(q) || remainder !== W'(r) || div_by_zero !== dbz[0]
          || busy !== 1'b0) begin
        errors++;
        $display("FAIL directed %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b busy=%b required lat=%0d q=%0d r=%0d dbz=%0d busy=0",
                 cases[i][0], cases[i][1], got_lat, quotient, remainder, div_by_zero, busy, lat, q, r, dbz);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || quotient !== W'(q) || remainder !== W'(r)) begin
        errors++;
        $display("FAIL hold %0d/%0d: done=%b q=%0d r=%0d required done=0 q=%0d r=%0d",
                 cases[i][0], cases[i][1], done, quotient, remainder, q, r);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept: busy=%b required 1", busy);
    end
    @(negedge clk);
    start = 1'b1; dividend = 4'd2; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!done && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != W + 1 || quotient !== 4'd4 || remainder !== 4'd1) begin
      errors++;
      $display("FAIL busy_ignore: lat=%0d q=%0d r=%0d required lat=%0d q=4 r=1", lat, quotient, remainder, W + 1);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(12, 5, lat);
    checks++;
    if (lat != W + 1 || quotient !== 4'd2 || remainder !== 4'd2) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d q=%0d r=%0d required lat=%0d q=2 r=2", lat, quotient, remainder, W + 1);
    end
    // Still inside the DONE cycle: issue the next request immediately.
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != W + 1 || quotient !== 4'd3 || remainder !== 4'd1) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d q=%0d r=%0d required lat=%0d q=3 r=1", lat, quotient, remainder, W + 1);
    end
  endtask

  task automatic test_abort;
    int lat;
    bit saw_done;
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: outputs=%h required 0", {busy, done, quotient, remainder, div_by_zero});
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (W + 2) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: saw_done=%b busy=%b required 0 0", saw_done, busy);
    end
    run_op(14, 4, lat);
    checks++;
    if (lat != W + 1 || quotient !== 4'd3 || remainder !== 4'd2) begin
      errors++;
      $display("FAIL abort_rerun: lat=%0d q=%0d r=%0d required lat=%0d q=3 r=2", lat, quotient, remainder, W + 1);
    end
  endtask

  task automatic test_sweep;
    int q, r, dbz, lat, got_lat;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        ref_div(a, b, q, r, dbz, lat);
        run_op(a, b, got_lat);
        checks++;
        if (got_lat != lat || quotient !== W'(q) || remainder !== W'(r) || div_by_zero !== dbz[0]) begin
          errors++;
          $display("FAIL sweep %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b required lat=%0d q=%0d r=%0d dbz=%0d",
                   a, b, got_lat, quotient, remainder, div_by_zero, lat, q, r, dbz);
        end
      end
    end
  endtask

  task automatic test_random;
    int a, b, q, r, dbz, lat, got_lat;
    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(0, (1 << W) - 1);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, (1 << W) - 1);
      ref_div(a, b, q, r, dbz, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_op(a, b, got_lat);
      checks++;
      if (got_lat != lat || quotient !== W'(q) || remainder !== W'(r) || div_by_zero !== dbz[0]) begin
        errors++;
        $display("FAIL random %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b required lat=%0d q=%0d r=%0d dbz=%0d",
                 a, b, got_lat, quotient, remainder, div_by_zero, lat, q, r, dbz);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
